// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Two-stage pipelined RV32 instruction encoder with a valid/ready handshake.
// It packs decoded fields (opcode, registers, funct codes, immediate and a
// format type) back into a 32-bit instruction word. This is the inverse of the
// decode-side immediate generator. The self-test instruction generator and the
// trace/replay path use it to rebuild instruction words.
//
// Optional feature macro: IMM_ENCODER_RANGE_CHECK_EN
//   defined     : a range checker flags immediates the selected format cannot
//                 represent (err_o), and err_cnt_o counts errored outputs.
//   not defined : no checker logic; err_o and err_cnt_o are tied to 0.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   flush_i      in   1   synchronous; drops all in-flight entries
//   in_valid_i   in   1   input fields valid
//   in_ready_o   out  1   encoder can accept this cycle
//   type_i       in   3   instruction format code (`RTYPE..`JTYPE)
//   opcode_i     in   7   instr[6:0]
//   rd_i         in   5   destination register
//   funct3_i     in   3   funct3
//   rs1_i        in   5   source register 1
//   rs2_i        in   5   source register 2
//   funct7_i     in   7   funct7 (R-type only)
//   imm_i        in  32   immediate as produced by decode
//   out_valid_o  out  1   instr_o valid
//   out_ready_i  in   1   consumer accepts
//   instr_o      out 32   packed instruction
//   err_o        out  1   immediate not representable (qualified by out_valid_o)
//   err_cnt_o    out  8   saturating count of errored outputs accepted
// -----------------------------------------------------------------------------

// Format codes normally come from Parameter.sv; fall back to these values when
// that file has not been compiled ahead of this one.
`ifndef RTYPE
`define RTYPE 3'd0
`endif
`ifndef ITYPE
`define ITYPE 3'd1
`endif
`ifndef STYPE
`define STYPE 3'd2
`endif
`ifndef BTYPE
`define BTYPE 3'd3
`endif
`ifndef UTYPE
`define UTYPE 3'd4
`endif
`ifndef JTYPE
`define JTYPE 3'd5
`endif

module imm_encoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  type_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    // Stage 1: registered input fields
    logic        s1_valid_reg;
    logic [2:0]  s1_type_reg;
    logic [6:0]  s1_opcode_reg;
    logic [4:0]  s1_rd_reg;
    logic [2:0]  s1_funct3_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [6:0]  s1_funct7_reg;
    logic [31:0] s1_imm_reg;

    // Stage 2: assembled output
    logic        out_valid_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_next;

    logic adv1;
    logic adv2;

    // Stage 2 can take a new entry when empty or when its entry leaves now;
    // stage 1 can take one when empty or when it moves into stage 2.
    assign adv2       = !out_valid_reg || out_ready_i;
    assign adv1       = !s1_valid_reg || adv2;
    assign in_ready_o = adv1;

    assign out_valid_o = out_valid_reg;
    assign instr_o     = instr_reg;

    // Pack stage-1 fields; bits a format cannot carry are simply not selected.
    always_comb begin
        instr_next = 32'd0;
        case (s1_type_reg)
            `RTYPE: instr_next = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg,
                                  s1_funct3_reg, s1_rd_reg, s1_opcode_reg};
            `ITYPE: instr_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                  s1_rd_reg, s1_opcode_reg};
            `STYPE: instr_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg,
                                  s1_funct3_reg, s1_imm_reg[4:0], s1_opcode_reg};
            `BTYPE: instr_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg,
                                  s1_rs1_reg, s1_funct3_reg, s1_imm_reg[4:1],
                                  s1_imm_reg[11], s1_opcode_reg};
            `UTYPE: instr_next = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
            `JTYPE: instr_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                  s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
            default: instr_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg  <= 1'b0;
            s1_type_reg   <= 3'd0;
            s1_opcode_reg <= 7'd0;
            s1_rd_reg     <= 5'd0;
            s1_funct3_reg <= 3'd0;
            s1_rs1_reg    <= 5'd0;
            s1_rs2_reg    <= 5'd0;
            s1_funct7_reg <= 7'd0;
            s1_imm_reg    <= 32'd0;
            out_valid_reg <= 1'b0;
            instr_reg     <= 32'd0;
        end else if (flush_i) begin
            // Flush wins over both transfers; data registers keep old values.
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (adv2) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    instr_reg <= instr_next;
                end
            end
            if (adv1) begin
                s1_valid_reg <= in_valid_i;
                if (in_valid_i) begin
                    s1_type_reg   <= type_i;
                    s1_opcode_reg <= opcode_i;
                    s1_rd_reg     <= rd_i;
                    s1_funct3_reg <= funct3_i;
                    s1_rs1_reg    <= rs1_i;
                    s1_rs2_reg    <= rs2_i;
                    s1_funct7_reg <= funct7_i;
                    s1_imm_reg    <= imm_i;
                end
            end
        end
    end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic       err_next;
    logic       s1_err_reg;
    logic       err_reg;
    logic [7:0] err_cnt_reg;

    // Error flag is computed on the raw inputs so it lands in stage 1
    // alongside the fields it describes.
    always_comb begin
        err_next = 1'b0;
        case (type_i)
            `RTYPE: err_next = 1'b0;
            `ITYPE,
            `STYPE: err_next = !(&imm_i[31:11] || ~|imm_i[31:11]);
            `BTYPE: err_next = !(&imm_i[31:12] || ~|imm_i[31:12]) || imm_i[0];
            `JTYPE: err_next = !(&imm_i[31:20] || ~|imm_i[31:20]) || imm_i[0];
            `UTYPE: err_next = |imm_i[11:0];
            default: err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_err_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else if (!flush_i) begin
            if (adv2 && s1_valid_reg) begin
                err_reg <= s1_err_reg;
            end
            if (adv1 && in_valid_i) begin
                s1_err_reg <= err_next;
            end
        end
    end

    // Counts accepted errored outputs, including one accepted in a flush
    // cycle; flush does not clear it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_reg <= 8'd0;
        end else if (out_valid_reg && out_ready_i && err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Directed self-checking bench for imm_encoder. Expected instruction words are
// hand-packed constants; error expectations depend on whether
// IMM_ENCODER_RANGE_CHECK_EN is defined for the build.
// -----------------------------------------------------------------------------
`ifndef RTYPE
`define RTYPE 3'd0
`endif
`ifndef ITYPE
`define ITYPE 3'd1
`endif
`ifndef STYPE
`define STYPE 3'd2
`endif
`ifndef BTYPE
`define BTYPE 3'd3
`endif
`ifndef UTYPE
`define UTYPE 3'd4
`endif
`ifndef JTYPE
`define JTYPE 3'd5
`endif

module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  type_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    imm_encoder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .type_i      (type_i),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .funct3_i    (funct3_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] f7, input logic [31:0] imm);
        type_i   = t;
        opcode_i = op;
        rd_i     = rd;
        funct3_i = f3;
        rs1_i    = rs1;
        rs2_i    = rs2;
        funct7_i = f7;
        imm_i    = imm;
    endtask

    // One unstalled beat: accepted at the first edge, visible after the second,
    // consumed at the third. bad = hand-judged range error for this beat.
    task automatic beat(input string tag, input logic [2:0] t, input logic [6:0] op,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input bit bad);
        drive(t, op, rd, f3, rs1, rs2, f7, imm);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk({tag, "_valid_n1"}, {31'd0, out_valid_o}, 32'd0);
        step();
        chk({tag, "_valid_n2"}, {31'd0, out_valid_o}, 32'd1);
        chk({tag, "_instr"}, instr_o, exp_instr);
        chk({tag, "_err"}, {31'd0, err_o}, {31'd0, RC & bad});
        step();
        if (RC && bad) exp_cnt++;
        chk({tag, "_cnt"}, {24'd0, err_cnt_o}, exp_cnt[31:0]);
        chk({tag, "_drained"}, {31'd0, out_valid_o}, 32'd0);
        $display("beat %s: instr=0x%08h err=%0d cnt=%0d", tag, exp_instr, RC & bad, exp_cnt);
    endtask

    // Fill both stages with two I-type beats while the consumer stalls.
    task automatic fill_two();
        out_ready_i = 1'b0;
        drive(`ITYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        in_valid_i = 1'b1;
        step();
        drive(`ITYPE, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drive(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        step();
        step();
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cnt", {24'd0, err_cnt_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        $display("reset: checked idle outputs");

        // Packing of each format plus the error boundaries
        beat("itype", `ITYPE, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFF_F800, 32'h8001_0093, 1'b0);
        beat("btype", `BTYPE, 7'h63, 5'd0, 3'd1, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0);
        beat("jtype", `JTYPE, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        beat("utype", `UTYPE, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        beat("rtype", `RTYPE, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hFFFF_FFFF, 32'h4031_00B3, 1'b0);
        beat("stype", `STYPE, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'hFFFF_FFF8, 32'hFE51_2C23, 1'b0);
        beat("ierr",  `ITYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, 1'b1);
        beat("berr",  `BTYPE, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0000_0003, 32'h0020_8163, 1'b1);
        beat("uerr",  `UTYPE, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        beat("unk",   3'd7,   7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0,        32'h0000_0000, 1'b1);

        // Backpressure: three back-to-back beats, only two accepted
        out_ready_i = 1'b0;
        drive(`ITYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        in_valid_i = 1'b1;
        chk("stall_rdy0", {31'd0, in_ready_o}, 32'd1);
        step();
        drive(`ITYPE, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("stall_rdy1", {31'd0, in_ready_o}, 32'd1);
        step();
        drive(`ITYPE, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("stall_rdy2", {31'd0, in_ready_o}, 32'd0);
        chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
        chk("stall_a", instr_o, 32'h0050_0093);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_rdy", {31'd0, in_ready_o}, 32'd0);
            chk("stall_hold_valid", {31'd0, out_valid_o}, 32'd1);
            chk("stall_hold_a", instr_o, 32'h0050_0093);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk("drain_b_valid", {31'd0, out_valid_o}, 32'd1);
        chk("drain_b", instr_o, 32'h0050_0113);
        step();
        chk("drain_empty", {31'd0, out_valid_o}, 32'd0);
        step();
        chk("drain_no_c", {31'd0, out_valid_o}, 32'd0);
        $display("stall: 2 of 3 beats accepted, drained in order");

        // Flush with two in flight and a beat presented in the flush cycle
        fill_two();
        chk("pre_flush_valid", {31'd0, out_valid_o}, 32'd1);
        drive(`ITYPE, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        step();
        step();
        chk("flush_dropped", {31'd0, out_valid_o}, 32'd0);
        chk("flush_cnt_kept", {24'd0, err_cnt_o}, exp_cnt[31:0]);
        $display("flush: pipeline emptied, presented beat dropped");

        // Output transfer completing in the flush cycle is still counted
        out_ready_i = 1'b0;
        drive(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        chk("fc_valid", {31'd0, out_valid_o}, 32'd1);
        chk("fc_err", {31'd0, err_o}, {31'd0, RC});
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        if (RC) exp_cnt++;
        chk("fc_cnt", {24'd0, err_cnt_o}, exp_cnt[31:0]);
        chk("fc_empty", {31'd0, out_valid_o}, 32'd0);
        $display("flush+accept: cnt=%0d", exp_cnt);

        // Asynchronous reset with two in flight
        fill_two();
        chk("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        exp_cnt = 0;
        chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_instr", instr_o, 32'd0);
        chk("arst_cnt", {24'd0, err_cnt_o}, 32'd0);
        step();
        chk("arst_valid_next", {31'd0, out_valid_o}, 32'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
        step();
        chk("arst_no_residue", {31'd0, out_valid_o}, 32'd0);
        $display("reset: in-flight entries cleared");

        // Counter saturation: stream 300 errored beats at full rate
        drive(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        in_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid_i = 1'b0;
        step();
        step();
        step();
        chk("sat_cnt", {24'd0, err_cnt_o}, RC ? 32'd255 : 32'd0);
        $display("saturation: cnt=%0d", err_cnt_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
